regbank_dump_ctrl: RTL and testbench

Debug-side sequencer that dumps the architectural register bank to the debug UART.
- On a start request it stalls the pipeline and takes over read port 1 of the register bank.
- It walks addresses 0..NUM_REGS-1 and serialises each 32-bit word as 4 bytes, MSB first, over a valid/ready byte stream.
- It then releases the port and the stall.
- It sits between the pipeline decode stage, register_bank and the UART transmitter.

---
 rtl/regbank_dump_ctrl_pkg.sv | 32 +++
 rtl/regbank_dump_ctrl_word_serializer.sv | 67 ++++++
 rtl/regbank_dump_ctrl.sv | 134 +++++++++++++
 tb/tb_regbank_dump_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_dump_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regbank_dump_ctrl_pkg
// Shared definitions for the debug-side blocks:
//   - default register-bank geometry (NUM_REGS, ADDR_W, DATA_W)
//   - UART byte-stream constants used by every block that feeds the debug UART
//   - dump sequencer state encodings (3-bit)
// ---------------------------------------------------------------------------
package regbank_dump_ctrl_pkg;

  // Register bank geometry
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  // UART byte stream.
  // Handshake: the producer raises tx_valid with tx_data and holds both stable
  // until the rising clk edge where tx_valid && tx_ready; that edge transfers
  // exactly one byte. The producer must not withdraw or change a pending byte.
  localparam int UART_BYTE_W    = 8;
  localparam int BYTES_PER_WORD = DATA_W / UART_BYTE_W;

  // Dump sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_STALL_WAIT = 3'd1;
  localparam state_t ST_ADDR       = 3'd2;
  localparam state_t ST_CAPTURE    = 3'd3;
  localparam state_t ST_SEND       = 3'd4;
  localparam state_t ST_NEXT       = 3'd5;
  localparam state_t ST_DONE       = 3'd6;

endpackage

// File: rtl/regbank_dump_ctrl_word_serializer.sv
// ---------------------------------------------------------------------------
// regbank_dump_ctrl_word_serializer
// Holds one DATA_W word and emits it as bytes, most significant byte first,
// on a valid/ready byte stream.
//   clk_i, rst_ni  clock, async active-low reset
//   load_i         capture data_i and restart at the first (MSB) byte
//   data_i         parallel word to serialise
//   send_i         present the current byte (drives tx_valid_o)
//   tx_ready_i     downstream accepts the byte at the clk edge
//   tx_data_o      current byte (0 when not sending)
//   tx_valid_o     byte valid
//   last_byte_o    current byte is the least significant one
//   accept_o       byte transfers at the next clk edge (valid && ready)
// ---------------------------------------------------------------------------
module regbank_dump_ctrl_word_serializer
  import regbank_dump_ctrl_pkg::UART_BYTE_W;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   send_i,
  input  logic                   tx_ready_i,
  output logic [UART_BYTE_W-1:0] tx_data_o,
  output logic                   tx_valid_o,
  output logic                   last_byte_o,
  output logic                   accept_o
);

  localparam int NB    = DATA_W / UART_BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shifted;

  // Shift the selected byte to the top so the MSB-first order is a fixed slice.
  assign shifted     = word_q << {idx_q, 3'b000};
  assign tx_valid_o  = send_i;
  assign tx_data_o   = send_i ? shifted[DATA_W-1 -: UART_BYTE_W] : '0;
  assign last_byte_o = (idx_q == IDX_W'(NB - 1));
  assign accept_o    = send_i & tx_ready_i;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load_i) begin
      word_d = data_i;
      idx_d  = '0;
    end else if (accept_o && !last_byte_o) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/regbank_dump_ctrl.sv
// ---------------------------------------------------------------------------
// regbank_dump_ctrl
// Debug sequencer that freezes the pipeline, borrows register-bank read
// port 1 and streams every register (address 0..NUM_REGS-1) to the debug
// UART as DATA_W/8 bytes each, MSB first.
//   clk_i              system clock, rising edge
//   rst_ni             async active-low reset
//   start_i            one-cycle dump request, honoured only when idle
//   pipe_dir_read1_i   pipeline's read-port-1 address
//   dir_read1_o        address actually sent to register bank port 1
//   bus1_i             register bank port-1 read data
//   stall_req_o        pipeline freeze request
//   stall_ack_i        pipeline is frozen (level)
//   tx_data_o          byte to UART transmitter
//   tx_valid_o         tx_data_o valid
//   tx_ready_i         transmitter takes the byte when valid && ready at clk
//   busy_o             sequencer not idle
//   done_o             one-cycle pulse when the whole bank has been sent
//   state_o            current sequencer state (debug visibility)
// ---------------------------------------------------------------------------
module regbank_dump_ctrl #(
  parameter int NUM_REGS = regbank_dump_ctrl_pkg::NUM_REGS,
  parameter int ADDR_W   = regbank_dump_ctrl_pkg::ADDR_W,
  parameter int DATA_W   = regbank_dump_ctrl_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pipe_dir_read1_i,
  output logic [ADDR_W-1:0] dir_read1_o,
  input  logic [DATA_W-1:0] bus1_i,
  output logic              stall_req_o,
  input  logic              stall_ack_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  import regbank_dump_ctrl_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic ser_load;
  logic ser_send;
  logic ser_last;
  logic ser_accept;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_STALL_WAIT;
          addr_d  = '0;
        end
      end
      ST_STALL_WAIT: begin
        if (stall_ack_i) state_d = ST_ADDR;
      end
      // One full cycle with the address applied so the bank read settles.
      ST_ADDR:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (ser_accept && ser_last) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic (all outputs decode from state, so reset clears them at once)
  // -------------------------------------------------------------------------
  always_comb begin
    stall_req_o = (state_q != ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    ser_load    = (state_q == ST_CAPTURE);
    ser_send    = (state_q == ST_SEND);
    // The pipeline owns port 1 until it has confirmed the freeze.
    if (state_q == ST_IDLE || state_q == ST_STALL_WAIT) begin
      dir_read1_o = pipe_dir_read1_i;
    end else begin
      dir_read1_o = addr_q;
    end
  end

  assign state_o = state_q;

  regbank_dump_ctrl_word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (ser_load),
    .data_i      (bus1_i),
    .send_i      (ser_send),
    .tx_ready_i  (tx_ready_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .last_byte_o (ser_last),
    .accept_o    (ser_accept)
  );

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
module tb_regbank_dump_ctrl;
  import regbank_dump_ctrl_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        start = 1'b0;
  logic [4:0]  pipe_dir_read1 = '0;
  logic [4:0]  dir_read1;
  logic [31:0] bus1;
  logic        stall_req;
  logic        stall_ack = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  // Register bank model: asynchronous read on port 1
  logic [31:0] regs [32];
  assign bus1 = regs[dir_read1];

  regbank_dump_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .pipe_dir_read1_i (pipe_dir_read1),
    .dir_read1_o      (dir_read1),
    .bus1_i           (bus1),
    .stall_req_o      (stall_req),
    .stall_ack_i      (stall_ack),
    .tx_data_o        (tx_data),
    .tx_valid_o       (tx_valid),
    .tx_ready_i       (tx_ready),
    .busy_o           (busy),
    .done_o           (done),
    .state_o          (state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_b[$];
  int byte_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  bit stall_gap = 1'b0;
  bit hold_pending = 1'b0;
  logic [7:0] held_data = '0;
  bit done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples at the falling edge, mid-cycle, away from input changes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        checks++;
        if (!(tx_valid === 1'b1 && tx_data === held_data)) begin
          errors++;
          $display("FAIL hold_stable actual=%0b/%0h required=1/%0h", tx_valid, tx_data, held_data);
        end
      end
      hold_pending = tx_valid && !tx_ready;
      held_data    = tx_data;
      if (tx_valid && tx_ready) begin
        got_b.push_back(tx_data);
        byte_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte actual=%0h required=none", tx_data);
        end else begin
          check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (done_prev) check("stall_drop_after_done", {31'h0, stall_req}, 32'h0);
      if (busy && !stall_req) stall_gap = 1'b1;
      if (busy && state != ST_STALL_WAIT && !stall_ack) begin
        errors++;
        $display("FAIL ack_dropped actual=0 required=1");
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      done_prev = done;
    end else begin
      hold_pending = 1'b0;
      done_prev    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic prep_expect();
    exp_q.delete();
    got_b.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(regs[r][31-8*b -: 8]);
    byte_cnt  = 0;
    done_cnt  = 0;
    stall_gap = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy, input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      if (rand_rdy) tx_ready = ($urandom_range(0, 99) < 30);
      n++;
    end
    tx_ready = 1'b1;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_dump(input string name);
    repeat (5) tick();
    check({name, "_bytes"}, byte_cnt, 128);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_stall_gap"}, {31'h0, stall_gap}, 32'h0);
    check({name, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Idle sweep vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] pipe;
    logic       ack;
    logic       rdy;
    logic [4:0] exp_dir;
    logic       exp_busy;
    logic       exp_valid;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [32];
  logic [7:0] exp_r1 [4];
  logic [7:0] exp_r3 [4];
  int n;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    regs[0] = 32'h0;
    regs[1] = 32'h3;
    regs[3] = 32'hDEADBEEF;
    exp_r1 = '{8'h00, 8'h00, 8'h00, 8'h03};
    exp_r3 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 32; i++) begin
      vecs[i].pipe      = 5'(i);
      vecs[i].ack       = i[0];
      vecs[i].rdy       = i[1];
      vecs[i].exp_dir   = 5'(i);
      vecs[i].exp_busy  = 1'b0;
      vecs[i].exp_valid = 1'b0;
      vecs[i].exp_stall = 1'b0;
    end

    // ---- reset values ----
    #1;
    check("rst_state", {29'h0, state}, {29'h0, ST_IDLE});
    check("rst_stall", {31'h0, stall_req}, 32'h0);
    check("rst_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_data", {24'h0, tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ---- idle sweep: port passthrough, nothing busy ----
    foreach (vecs[i]) begin
      pipe_dir_read1 = vecs[i].pipe;
      stall_ack      = vecs[i].ack;
      tx_ready       = vecs[i].rdy;
      @(negedge clk);
      check("idle_dir", {27'h0, dir_read1}, {27'h0, vecs[i].exp_dir});
      check("idle_busy", {31'h0, busy}, {31'h0, vecs[i].exp_busy});
      check("idle_valid", {31'h0, tx_valid}, {31'h0, vecs[i].exp_valid});
      check("idle_stall", {31'h0, stall_req}, {31'h0, vecs[i].exp_stall});
      tick();
    end

    // ---- scenario 1: full dump, ready and ack high ----
    stall_ack = 1'b1;
    tx_ready  = 1'b1;
    prep_expect();
    pulse_start();
    wait_done(400, 1'b0, "s1");
    check("s1_latency", done_cyc - start_cyc + 1, 226);
    check_dump("s1");
    for (int b = 0; b < 4; b++) begin
      check("s1_r1_byte", {24'h0, got_b[4+b]}, {24'h0, exp_r1[b]});
      check("s1_r3_byte", {24'h0, got_b[12+b]}, {24'h0, exp_r3[b]});
    end

    // ---- scenario 2: stall_ack late ----
    stall_ack      = 1'b0;
    pipe_dir_read1 = 5'd7;
    prep_expect();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("sw_dir", {27'h0, dir_read1}, 32'd7);
      check("sw_valid", {31'h0, tx_valid}, 32'h0);
      check("sw_state", {29'h0, state}, {29'h0, ST_STALL_WAIT});
      check("sw_stall", {31'h0, stall_req}, 32'h1);
      tick();
    end
    stall_ack = 1'b1;
    @(negedge clk);
    check("sw_still_wait", {29'h0, state}, {29'h0, ST_STALL_WAIT});
    @(negedge clk);
    check("sw_addr_state", {29'h0, state}, {29'h0, ST_ADDR});
    check("sw_addr_dir", {27'h0, dir_read1}, 32'd0);
    wait_done(400, 1'b0, "s2");
    check_dump("s2");

    // ---- scenario 3: tx_ready random, ~30% high ----
    prep_expect();
    pulse_start();
    wait_done(4000, 1'b1, "s3");
    check_dump("s3");

    // ---- scenario 4: start again mid-dump ----
    prep_expect();
    pulse_start();
    n = 0;
    while (byte_cnt < 40 && n < 400) begin
      tick();
      n++;
    end
    check("s4_reach_40", {31'h0, byte_cnt >= 40}, 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, 1'b0, "s4");
    repeat (30) tick();
    check_dump("s4");

    // ---- scenario 5: reset during SEND of r10 ----
    prep_expect();
    pulse_start();
    n = 0;
    while (byte_cnt < 41 && n < 400) begin
      tick();
      n++;
    end
    check("s5_in_r10", {29'h0, state}, {29'h0, ST_SEND});
    rst_n = 1'b0;
    #1;
    check("s5_rst_state", {29'h0, state}, {29'h0, ST_IDLE});
    check("s5_rst_stall", {31'h0, stall_req}, 32'h0);
    check("s5_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("s5_rst_data", {24'h0, tx_data}, 32'h0);
    check("s5_rst_busy", {31'h0, busy}, 32'h0);
    check("s5_rst_dir", {27'h0, dir_read1}, {27'h0, pipe_dir_read1});
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("s5_no_done", done_cnt, 0);
    prep_expect();
    pulse_start();
    wait_done(400, 1'b0, "s5");
    check("s5_first_byte", {24'h0, got_b[0]}, 32'h0);
    check_dump("s5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
